// File: rtl/igr_dpm_pkg.sv
// Shared types and parameter defaults for the ingress dirty pod manager.
// pod_t carries one pod: POD_PTRS pointer slots (slot i at ptrs[i]) plus
// the number of valid slots.
package igr_dpm_pkg;

  localparam int unsigned PTR_W      = 20;
  localparam int unsigned POD_PTRS   = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned MAX_OUT    = 4;
  localparam int unsigned FLUSH_CYC  = 64;

  localparam int unsigned CNT_W = $clog2(POD_PTRS + 1);

  typedef logic [CNT_W-1:0] pod_cnt_t;

  typedef struct packed {
    logic [POD_PTRS-1:0][PTR_W-1:0] ptrs;
    pod_cnt_t                       cnt;
  } pod_t;

endpackage

// File: rtl/igr_dpm_fifo.sv
// Synchronous show-ahead FIFO of pods.
//   wr_en/wr_data : push (ignored when full)
//   rd_en         : pop (ignored when empty); rd_data shows the head entry
//   full/empty    : derived from the registered level
//   level         : number of queued pods
module igr_dpm_fifo
  import igr_dpm_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  pod_t                       wr_data,
  input  logic                       rd_en,
  output pod_t                       rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  pod_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/igr_dirty_pod_mgr.sv
// Ingress dirty pod manager: packs released dirty segment pointers into
// pods, queues them, and serves one pod per egress request.
//   ptr_valid/ptr/ptr_ready : pointer input handshake
//   pod_req                 : one-cycle request pulse from egress
//   pod_valid               : one-cycle pulse, pod_ptrs/pod_cnt valid (held after)
//   fifo_level              : queued pods
//   err_req_ovf             : sticky, a request arrived with MAX_OUT outstanding
module igr_dirty_pod_mgr #(
  parameter int unsigned PTR_W      = igr_dpm_pkg::PTR_W,
  parameter int unsigned POD_PTRS   = igr_dpm_pkg::POD_PTRS,
  parameter int unsigned FIFO_DEPTH = igr_dpm_pkg::FIFO_DEPTH,
  parameter int unsigned MAX_OUT    = igr_dpm_pkg::MAX_OUT,
  parameter int unsigned FLUSH_CYC  = igr_dpm_pkg::FLUSH_CYC
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ptr_valid,
  input  logic [PTR_W-1:0]                  ptr,
  output logic                              ptr_ready,
  input  logic                              pod_req,
  output logic                              pod_valid,
  output logic [POD_PTRS*PTR_W-1:0]         pod_ptrs,
  output logic [$clog2(POD_PTRS+1)-1:0]     pod_cnt,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              err_req_ovf
);

  import igr_dpm_pkg::*;

  localparam int unsigned SW = $clog2(POD_PTRS);
  localparam int unsigned TW = $clog2(FLUSH_CYC);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);

  logic [POD_PTRS-1:0][PTR_W-1:0] stage_ptrs;
  pod_cnt_t                       stage_cnt;
  logic [TW-1:0]                  idle_cnt;
  logic [OW-1:0]                  out_cnt;

  logic accept, last_slot, full_push, flush_push, push;
  logic req_ok, pop;
  logic fifo_full, fifo_empty;
  pod_t push_pod, pop_pod;

  // Only the final slot can stall: earlier slots go to staging, which
  // never pushes except via the idle flush (itself gated on !fifo_full).
  assign last_slot = (stage_cnt == pod_cnt_t'(POD_PTRS - 1));
  assign ptr_ready = !(last_slot && fifo_full);

  always_comb begin
    accept     = ptr_valid && ptr_ready;
    full_push  = accept && last_slot;
    flush_push = !accept && (stage_cnt != '0) &&
                 (idle_cnt == TW'(FLUSH_CYC - 1)) && !fifo_full;
    push       = full_push || flush_push;
    // Staging slots beyond stage_cnt are kept at zero, so a flushed
    // partial pod already has its unused slots cleared.
    push_pod.ptrs = stage_ptrs;
    push_pod.cnt  = stage_cnt;
    if (full_push) begin
      push_pod.ptrs[POD_PTRS-1] = ptr;
      push_pod.cnt              = pod_cnt_t'(POD_PTRS);
    end
    req_ok = pod_req && (out_cnt != OW'(MAX_OUT));
    pop    = (out_cnt != '0) && !fifo_empty;
  end

  igr_dpm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_pod),
    .rd_en   (pop),
    .rd_data (pop_pod),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_ptrs  <= '0;
      stage_cnt   <= '0;
      idle_cnt    <= '0;
      out_cnt     <= '0;
      pod_valid   <= 1'b0;
      pod_ptrs    <= '0;
      pod_cnt     <= '0;
      err_req_ovf <= 1'b0;
    end else begin
      if (push) begin
        stage_ptrs <= '0;
        stage_cnt  <= '0;
      end else if (accept) begin
        stage_ptrs[stage_cnt[SW-1:0]] <= ptr;
        stage_cnt                     <= stage_cnt + pod_cnt_t'(1);
      end

      // Saturates at FLUSH_CYC-1 so a flush blocked by a full FIFO fires
      // as soon as space frees.
      if (accept || push) begin
        idle_cnt <= '0;
      end else if ((stage_cnt != '0) && (idle_cnt != TW'(FLUSH_CYC - 1))) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      case ({req_ok, pop})
        2'b10:   out_cnt <= out_cnt + OW'(1);
        2'b01:   out_cnt <= out_cnt - OW'(1);
        default: out_cnt <= out_cnt;
      endcase

      if (pod_req && !req_ok) err_req_ovf <= 1'b1;

      pod_valid <= pop;
      if (pop) begin
        pod_ptrs <= pop_pod.ptrs;
        pod_cnt  <= pop_pod.cnt;
      end
    end
  end

endmodule

// File: tb/tb_igr_dirty_pod_mgr.sv
// Self-checking bench for igr_dirty_pod_mgr. Expected pods are queued when
// the stimulus that creates them is driven and compared by a monitor on
// each pod_valid pulse. Inputs change and outputs are sampled on negedges.
module tb_igr_dirty_pod_mgr;

  localparam int PTR_W      = 20;
  localparam int POD_PTRS   = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int MAX_OUT    = 4;
  localparam int FLUSH_CYC  = 64;
  localparam int CW         = $clog2(POD_PTRS + 1);
  localparam int LW         = $clog2(FIFO_DEPTH + 1);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      ptr_valid = 1'b0;
  logic [PTR_W-1:0]          ptr = '0;
  logic                      ptr_ready;
  logic                      pod_req = 1'b0;
  logic                      pod_valid;
  logic [POD_PTRS*PTR_W-1:0] pod_ptrs;
  logic [CW-1:0]             pod_cnt;
  logic [LW-1:0]             fifo_level;
  logic                      err_req_ovf;

  typedef struct {
    logic [POD_PTRS*PTR_W-1:0] ptrs;
    logic [CW-1:0]             cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pods   = 0;

  igr_dirty_pod_mgr #(
    .PTR_W      (PTR_W),
    .POD_PTRS   (POD_PTRS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUT    (MAX_OUT),
    .FLUSH_CYC  (FLUSH_CYC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ptr_valid   (ptr_valid),
    .ptr         (ptr),
    .ptr_ready   (ptr_ready),
    .pod_req     (pod_req),
    .pod_valid   (pod_valid),
    .pod_ptrs    (pod_ptrs),
    .pod_cnt     (pod_cnt),
    .fifo_level  (fifo_level),
    .err_req_ovf (err_req_ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every delivered pod must match the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pod_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pod: got cnt=%0d ptrs=%h, none expected", pod_cnt, pod_ptrs);
      end else begin
        e = exp_q.pop_front();
        if (pod_ptrs !== e.ptrs || pod_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL pod_content: got cnt=%0d ptrs=%h, want cnt=%0d ptrs=%h",
                   pod_cnt, pod_ptrs, e.cnt, e.ptrs);
        end
      end
      n_pods++;
    end
  end

  task automatic send_ptr(input logic [PTR_W-1:0] v);
    ptr_valid = 1'b1;
    ptr       = v;
    @(negedge clk);
    ptr_valid = 1'b0;
  endtask

  task automatic req_pulse();
    pod_req = 1'b1;
    @(negedge clk);
    pod_req = 1'b0;
  endtask

  // Sends n full pods; rnd selects random pointer values instead of base+i.
  task automatic push_pods(input int n, input int base, input bit rnd);
    exp_t             e;
    logic [PTR_W-1:0] v;
    for (int p = 0; p < n; p++) begin
      e.ptrs = '0;
      e.cnt  = CW'(POD_PTRS);
      for (int k = 0; k < POD_PTRS; k++) begin
        v = rnd ? PTR_W'($urandom()) : PTR_W'(base + p * POD_PTRS + k);
        e.ptrs[k*PTR_W +: PTR_W] = v;
        send_ptr(v);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pod_valid, pod_ptrs, pod_cnt, fifo_level, err_req_ovf, ptr_ready} !==
        {1'b0, {(POD_PTRS*PTR_W){1'b0}}, {CW{1'b0}}, {LW{1'b0}}, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values: got valid=%b cnt=%0d lvl=%0d ovf=%b rdy=%b, want 0 0 0 0 1",
               pod_valid, pod_cnt, fifo_level, err_req_ovf, ptr_ready);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (n_pods !== 0 || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got pods=%0d lvl=%0d, want 0 0", n_pods, fifo_level);
    end
  endtask

  task automatic test_full_pod();
    int n0 = n_pods;
    push_pods(1, 'h100, 1'b0);
    n_checks++;
    if (fifo_level !== LW'(1)) begin
      n_fail++;
      $display("FAIL full_pod_level: got %0d, want 1", fifo_level);
    end
    req_pulse();
    #1;
    n_checks++;
    if (pod_valid !== 1'b0 || n_pods !== n0) begin
      n_fail++;
      $display("FAIL full_pod_early: got valid=%b, want 0 at T+1", pod_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (pod_valid !== 1'b1 || pod_cnt !== CW'(8) || fifo_level !== '0) begin
      n_fail++;
      $display("FAIL full_pod_latency: got valid=%b cnt=%0d lvl=%0d, want 1 8 0",
               pod_valid, pod_cnt, fifo_level);
    end
    @(negedge clk);
    n_checks++;
    if (pod_valid !== 1'b0 || pod_cnt !== CW'(8) || pod_ptrs[7*PTR_W +: PTR_W] !== PTR_W'('h107)) begin
      n_fail++;
      $display("FAIL full_pod_hold: got valid=%b cnt=%0d slot7=%h, want 0 8 00107",
               pod_valid, pod_cnt, pod_ptrs[7*PTR_W +: PTR_W]);
    end
  endtask

  task automatic test_partial_flush();
    exp_t e;
    int   k  = 0;
    int   n0 = n_pods;
    e.ptrs = '0;
    e.cnt  = CW'(3);
    for (int i = 0; i < 3; i++) begin
      e.ptrs[i*PTR_W +: PTR_W] = PTR_W'('h200 + i);
      send_ptr(PTR_W'('h200 + i));
    end
    exp_q.push_back(e);
    while (fifo_level == '0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k !== FLUSH_CYC) begin
      n_fail++;
      $display("FAIL flush_delay: got %0d cycles after last accept, want %0d", k, FLUSH_CYC);
    end
    repeat (5) @(negedge clk);
    req_pulse();
    k = 0;
    while (n_pods == n0 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (n_pods !== n0 + 1 || pod_cnt !== CW'(3)) begin
      n_fail++;
      $display("FAIL flush_pod: got pods=%0d cnt=%0d, want %0d 3", n_pods - n0, pod_cnt, 1);
    end
  endtask

  task automatic test_pending();
    exp_t             e;
    logic [PTR_W-1:0] v;
    int               n0 = n_pods;
    for (int i = 0; i < 3; i++) req_pulse();
    for (int j = 0; j < 3 * POD_PTRS; j++) begin
      if (j % POD_PTRS == 0) begin
        e.ptrs = '0;
        e.cnt  = CW'(POD_PTRS);
      end
      v = PTR_W'('h1000 + j);
      e.ptrs[(j % POD_PTRS)*PTR_W +: PTR_W] = v;
      send_ptr(v);
      if (j % POD_PTRS == POD_PTRS - 1) exp_q.push_back(e);
      // Each pod arrives one cycle after its FIFO write.
      n_checks++;
      if (pod_valid !== (j == 8 || j == 16)) begin
        n_fail++;
        $display("FAIL pending_timing: after ptr %0d got valid=%b, want %b",
                 j, pod_valid, (j == 8 || j == 16));
      end
    end
    @(negedge clk);
    n_checks++;
    if (pod_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_last: got valid=%b, want 1", pod_valid);
    end
    push_pods(1, 'h2000, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (n_pods !== n0 + 3 || fifo_level !== LW'(1)) begin
      n_fail++;
      $display("FAIL pending_accum: got pods=%0d lvl=%0d, want 3 1", n_pods - n0, fifo_level);
    end
  endtask

  task automatic test_backpressure();
    exp_t             e;
    logic [PTR_W-1:0] v;
    push_pods(FIFO_DEPTH - 1, 0, 1'b1);
    e.ptrs = '0;
    e.cnt  = CW'(POD_PTRS);
    for (int k = 0; k < POD_PTRS - 1; k++) begin
      v = PTR_W'($urandom());
      e.ptrs[k*PTR_W +: PTR_W] = v;
      send_ptr(v);
    end
    n_checks++;
    if (ptr_ready !== 1'b0 || fifo_level !== LW'(FIFO_DEPTH)) begin
      n_fail++;
      $display("FAIL bp_stall: got rdy=%b lvl=%0d, want 0 16", ptr_ready, fifo_level);
    end
    v = PTR_W'('hABCDE);
    e.ptrs[(POD_PTRS-1)*PTR_W +: PTR_W] = v;
    exp_q.push_back(e);
    ptr_valid = 1'b1;
    ptr       = v;
    req_pulse();
    n_checks++;
    if (ptr_ready !== 1'b0 || fifo_level !== LW'(FIFO_DEPTH)) begin
      n_fail++;
      $display("FAIL bp_before_pop: got rdy=%b lvl=%0d, want 0 16", ptr_ready, fifo_level);
    end
    @(negedge clk);
    n_checks++;
    if (ptr_ready !== 1'b1 || fifo_level !== LW'(FIFO_DEPTH - 1)) begin
      n_fail++;
      $display("FAIL bp_after_pop: got rdy=%b lvl=%0d, want 1 15", ptr_ready, fifo_level);
    end
    @(negedge clk);
    ptr_valid = 1'b0;
    n_checks++;
    if (fifo_level !== LW'(FIFO_DEPTH)) begin
      n_fail++;
      $display("FAIL bp_accept: got lvl=%0d, want 16", fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = n_pods;
    for (int i = 0; i < FIFO_DEPTH; i++) req_pulse();
    @(negedge clk);
    #1;
    n_checks++;
    if (n_pods !== n0 + FIFO_DEPTH || fifo_level !== '0 || err_req_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back: got pods=%0d lvl=%0d ovf=%b, want 16 0 0",
               n_pods - n0, fifo_level, err_req_ovf);
    end
  endtask

  task automatic test_overflow_reset();
    int n0 = n_pods;
    for (int i = 0; i < MAX_OUT; i++) req_pulse();
    n_checks++;
    if (err_req_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_at_max: got %b, want 0", err_req_ovf);
    end
    req_pulse();
    n_checks++;
    if (err_req_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b, want 1", err_req_ovf);
    end
    // Only MAX_OUT of the 5 requests were kept.
    push_pods(MAX_OUT + 1, 'h4000, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (n_pods !== n0 + MAX_OUT || fifo_level !== LW'(1)) begin
      n_fail++;
      $display("FAIL ovf_served: got pods=%0d lvl=%0d, want 4 1", n_pods - n0, fifo_level);
    end
    for (int i = 0; i < 3; i++) send_ptr(PTR_W'('h5000 + i));
    pod_req = 1'b1;
    @(negedge clk);
    pod_req = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({pod_valid, pod_cnt, fifo_level, err_req_ovf, ptr_ready} !==
        {1'b0, {CW{1'b0}}, {LW{1'b0}}, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midreset_values: got valid=%b cnt=%0d lvl=%0d ovf=%b rdy=%b, want 0 0 0 0 1",
               pod_valid, pod_cnt, fifo_level, err_req_ovf, ptr_ready);
    end
    rst_n = 1'b1;
    n0    = n_pods;
    repeat (FLUSH_CYC + 20) @(negedge clk);
    #1;
    n_checks++;
    if (n_pods !== n0 || fifo_level !== '0 || err_req_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: got pods=%0d lvl=%0d ovf=%b, want 0 0 0",
               n_pods - n0, fifo_level, err_req_ovf);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_pod();
    test_partial_flush();
    test_pending();
    test_backpressure();
    test_back_to_back();
    test_overflow_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_pods: got %0d undelivered, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/igr_dirty_pod_mgr.md
# igr_dirty_pod_mgr

Ingress Dirty Pod Manager. It collects dirty segment pointers released by ingress and packs them into fixed-size pods. Pods are queued in a FIFO and handed to the egress Dirty Pointer Broker on request. It is the ingress-side responder of the egress pod request path.

## Interface
- PTR_W, 20, segment pointer width
- POD_PTRS, 8, pointers per pod
- FIFO_DEPTH, 16, pod FIFO entries (power of 2)
- MAX_OUT, 4, max outstanding egress requests
- FLUSH_CYC, 64, idle cycles before a partial pod is pushed
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- ptr_valid  in  1  dirty pointer offered
- ptr  in  PTR_W  dirty pointer value
- ptr_ready  out  1  pointer accepted when valid&&ready
- pod_req  in  1  one-cycle pulse; one pod requested by egress DPB
- pod_valid  out  1  one-cycle pulse; pod delivered
- pod_ptrs  out  POD_PTRS*PTR_W  pod contents; slot i at [i*PTR_W +: PTR_W]
- pod_cnt  out  $clog2(POD_PTRS+1)  valid slots in pod (1..POD_PTRS)
- fifo_level  out  $clog2(FIFO_DEPTH+1)  queued pods
- err_req_ovf  out  1  sticky; request dropped at MAX_OUT

## Operation
- Reset values: all outputs 0 except ptr_ready=1. Staging count, idle timer, outstanding count and FIFO pointers are all 0.
- Packer: accepted pointers fill staging slots in order from slot 0.
  - When slot POD_PTRS-1 is accepted, {ptr, staging} is written to the FIFO in the same cycle with cnt=POD_PTRS, and staging resets to 0.
- ptr_ready = !(stage_cnt==POD_PTRS-1 && fifo_full). fifo_full is the registered state; there is no read/write bypass.
- Idle flush: the idle timer increments each cycle with stage_cnt>0 and no accept. It clears on accept or on push.
  - At timer==FLUSH_CYC-1 with the FIFO not full, the partial pod is pushed with cnt=stage_cnt. Unused slots are 0.
  - If the FIFO is full, the timer holds until space frees.
- Responder: out_cnt (0..MAX_OUT) counts requests not yet served.
  - A pod_req at out_cnt==MAX_OUT is dropped, sets err_req_ovf, and leaves out_cnt unchanged.
- Pop condition: out_cnt>0 && !fifo_empty, both registered. A pop decrements out_cnt.
  - A simultaneous request and pop leaves out_cnt unchanged.
- A pop and a push in the same cycle are both legal. fifo_level is unchanged.
- Pods with no outstanding request stay in the FIFO. Requests with no pods stay pending indefinitely.

## Timing
- FIFO write at cycle N: the entry is poppable at N+1.
- pod_req at N: out_cnt updates at N+1, the earliest pop is at N+1, and pod_valid/pod_ptrs/pod_cnt are registered out at N+2.
- Request-to-pod latency is 2 cycles minimum.
- Sustained rate: 1 pod/cycle out, and 1 pointer/cycle in.
- pod_ptrs/pod_cnt hold their value between pod_valid pulses.
- Reset mid-operation: staging, queued pods and pending requests are discarded. err_req_ovf clears. Egress must reissue requests.

## Structure
- igr_dpm_pkg holds:
  - the parameter defaults;
  - the pod_t struct {ptrs[POD_PTRS], cnt};
  - the pod_cnt_t width typedef.
- Sub-module igr_dpm_fifo: synchronous FIFO of pod_t with full, empty and level outputs. The top contains the packer, the idle timer and the responder counter.

## Test plan
- Reset: all outputs 0 and ptr_ready=1. Release reset and run 10 idle cycles: no pod_valid.
- Full pod:
  - Stimulus: pointers 0x100..0x107 back-to-back, then pod_req at cycle T.
  - Response: pod_valid at T+2, slots 0x100..0x107, pod_cnt=8, fifo_level 1->0.
- Partial flush:
  - Stimulus: pointers 0x200..0x202, then idle.
  - Response: the push happens 64 cycles after the last accept, with pod_cnt=3 and slots 3..7 = 0. A later pod_req returns this pod.
- Pending requests:
  - Stimulus: 3 pod_req pulses, then 24 pointers.
  - Response: 3 pod_valid pulses, each 1 cycle after its FIFO write. out_cnt ends at 0. Further pods accumulate in the FIFO.
- Backpressure:
  - Stimulus: fill 16 pods plus 7 staged pointers.
  - Response: ptr_ready=0. After a pod_req, ptr_ready=1 the cycle after the pop, and the 8th pointer is accepted.
- Overflow and reset mid-operation:
  - Stimulus: 5 pod_req pulses with an empty FIFO.
  - Response: out_cnt=4 and err_req_ovf=1.
  - Stimulus: assert rst_n low.
  - Response: all state clears, err_req_ovf=0, and there is no stale pod_valid afterwards.
